// File: rtl/pipe_elastic_reg_pkg.sv
// Shared constants, types and helpers for the elastic pipeline-stage register.
// Holds the NOP payload encoding, the default counter width and the main-register update selector.
package pipe_elastic_reg_pkg;

    localparam logic [31:0] NOP_DEFAULT   = 32'h0000_0013;
    localparam int          CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_LOAD_IN,
        MAIN_LOAD_SKID,
        MAIN_DRAIN
    } mainSel_t;

    // Number of live entries thrown away by a flush (0..2).
    function automatic logic [1:0] flushInc(input logic mainValid, input logic skidValid);
        return {1'b0, mainValid} + {1'b0, skidValid};
    endfunction

endpackage

// File: rtl/pipe_elastic_reg_sat_cnt.sv
// Saturating performance counter: adds 0..2 per cycle, sticks at all-ones, synchronous clear.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [1:0]       i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    assign w_sum = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, i_inc};

    // The extra sum bit flags an overflow, which pins the count at its maximum instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_sum[CNT_W]) begin
            r_cnt <= '1;
        end else begin
            r_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid entry,
// bubble/stall control and saturating stall/flush counters.
module pipe_elastic_reg
    import pipe_elastic_reg_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               SKID    = 1,
    parameter logic [WIDTH-1:0] DEFAULT = '0,
    parameter int               CNT_W   = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_bubble,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic             w_hold;
    logic             r_mainValid;
    logic [WIDTH-1:0] r_mainData;
    logic             w_skidValid;
    logic [WIDTH-1:0] w_skidData;
    logic             w_inReady;
    logic             w_outValid;
    logic             w_inFire;
    logic             w_outFire;
    mainSel_t         w_mainSel;
    logic [1:0]       w_stallInc;
    logic [1:0]       w_flushInc;

    assign w_hold     = i_stall | i_bubble;
    assign w_outValid = r_mainValid & ~w_hold;
    assign w_outFire  = w_outValid & i_out_ready;
    assign w_inFire   = i_in_valid & w_inReady;

    generate
        if (SKID != 0) begin : g_skid
            logic             r_skidValid;
            logic [WIDTH-1:0] r_skidData;
            logic             w_skidLoad;

            // Input arrives while main is occupied and not draining: park it in the skid entry.
            assign w_skidLoad = w_inFire & r_mainValid & ~w_outFire;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_skidValid <= 1'b0;
                    r_skidData  <= DEFAULT;
                end else if (i_bubble) begin
                    r_skidValid <= 1'b0;
                    r_skidData  <= DEFAULT;
                end else if (w_skidLoad) begin
                    r_skidValid <= 1'b1;
                    r_skidData  <= i_in_data;
                end else if (r_skidValid && w_outFire) begin
                    r_skidValid <= 1'b0;
                    r_skidData  <= DEFAULT;
                end
            end

            assign w_skidValid = r_skidValid;
            assign w_skidData  = r_skidData;
            // Ready depends only on registered state, cutting the out_ready -> in_ready path.
            assign w_inReady   = ~r_skidValid & ~w_hold & ~i_rst;
        end else begin : g_noskid
            assign w_skidValid = 1'b0;
            assign w_skidData  = DEFAULT;
            assign w_inReady   = (~r_mainValid | i_out_ready) & ~w_hold & ~i_rst;
        end
    endgenerate

    // A waiting skid entry always refills main before any newer input, preserving order.
    always_comb begin
        w_mainSel = MAIN_HOLD;
        if (w_skidValid && w_outFire) begin
            w_mainSel = MAIN_LOAD_SKID;
        end else if (w_inFire && (!r_mainValid || w_outFire)) begin
            w_mainSel = MAIN_LOAD_IN;
        end else if (w_outFire) begin
            w_mainSel = MAIN_DRAIN;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mainValid <= 1'b0;
            r_mainData  <= DEFAULT;
        end else if (i_bubble) begin
            r_mainValid <= 1'b0;
            r_mainData  <= DEFAULT;
        end else begin
            case (w_mainSel)
                MAIN_LOAD_IN: begin
                    r_mainValid <= 1'b1;
                    r_mainData  <= i_in_data;
                end
                MAIN_LOAD_SKID: begin
                    r_mainValid <= 1'b1;
                    r_mainData  <= w_skidData;
                end
                MAIN_DRAIN: begin
                    r_mainValid <= 1'b0;
                    r_mainData  <= DEFAULT;
                end
                default: begin
                    r_mainValid <= r_mainValid;
                    r_mainData  <= r_mainData;
                end
            endcase
        end
    end

    assign w_stallInc = {1'b0, i_stall & ~i_bubble};
    assign w_flushInc = i_bubble ? flushInc(r_mainValid, w_skidValid) : 2'd0;

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stallCnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (w_stallInc),
        .o_cnt (o_stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flushCnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (w_flushInc),
        .o_cnt (o_flush_cnt)
    );

    assign o_in_ready  = w_inReady;
    assign o_out_valid = w_outValid;
    assign o_out_data  = r_mainData;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg: a SKID=1/CNT_W=16 instance and a SKID=0/CNT_W=2 instance.
module tb_pipe_elastic_reg;
    import pipe_elastic_reg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        r1, st1, bb1, iv1, or1, cc1;
    logic [31:0] id1;
    logic        ir1, ov1;
    logic [31:0] od1;
    logic [15:0] sc1, fc1;

    logic        r0, st0, bb0, iv0, or0, cc0;
    logic [31:0] id0;
    logic        ir0, ov0;
    logic [31:0] od0;
    logic [1:0]  sc0, fc0;

    pipe_elastic_reg #(.WIDTH(32), .SKID(1), .DEFAULT(NOP_DEFAULT), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(r1), .i_stall(st1), .i_bubble(bb1),
        .i_in_valid(iv1), .o_in_ready(ir1), .i_in_data(id1),
        .o_out_valid(ov1), .i_out_ready(or1), .o_out_data(od1),
        .i_cnt_clr(cc1), .o_stall_cnt(sc1), .o_flush_cnt(fc1)
    );

    pipe_elastic_reg #(.WIDTH(32), .SKID(0), .DEFAULT(NOP_DEFAULT), .CNT_W(2)) dut0 (
        .i_clk(clk), .i_rst(r0), .i_stall(st0), .i_bubble(bb0),
        .i_in_valid(iv0), .o_in_ready(ir0), .i_in_data(id0),
        .o_out_valid(ov0), .i_out_ready(or0), .o_out_data(od0),
        .i_cnt_clr(cc0), .o_stall_cnt(sc0), .o_flush_cnt(fc0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        r1 = 1'b1; st1 = 1'b0; bb1 = 1'b0; iv1 = 1'b0; or1 = 1'b1; cc1 = 1'b0; id1 = '0;
        r0 = 1'b1; st0 = 1'b0; bb0 = 1'b0; iv0 = 1'b0; or0 = 1'b1; cc0 = 1'b0; id0 = '0;
        #1;
        checks++; if (ir1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready1 got=%0b exp=0", ir1); end
        checks++; if (ov1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid1 got=%0b exp=0", ov1); end
        checks++; if (od1 !== NOP_DEFAULT) begin failures++; $display("[TB] FAIL reset_data1 got=%h exp=%h", od1, NOP_DEFAULT); end
        checks++; if (sc1 !== 16'd0 || fc1 !== 16'd0) begin failures++; $display("[TB] FAIL reset_cnt1 got=%0d/%0d exp=0/0", sc1, fc1); end
        checks++; if (ir0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready0 got=%0b exp=0", ir0); end
        checks++; if (od0 !== NOP_DEFAULT) begin failures++; $display("[TB] FAIL reset_data0 got=%h exp=%h", od0, NOP_DEFAULT); end
        tick;
        tick;
        r1 = 1'b0;
        r0 = 1'b0;
        #1;
        checks++; if (ir1 !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready1 got=%0b exp=1", ir1); end
        tick;
    endtask

    task automatic test_back_to_back;
        or1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            iv1 = (k < 4);
            id1 = 32'hA000_0001 + k;
            #1;
            if (k == 0) begin
                checks++; if (ir1 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready got=%0b exp=1", ir1); end
                checks++; if (ov1 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid0 got=%0b exp=0", ov1); end
            end else begin
                checks++; if (ov1 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid%0d got=%0b exp=1", k, ov1); end
                checks++; if (od1 !== 32'hA000_0000 + k) begin failures++; $display("[TB] FAIL b2b_data%0d got=%h exp=%h", k, od1, 32'hA000_0000 + k); end
            end
            tick;
        end
        #1;
        checks++; if (ov1 !== 1'b0 || od1 !== NOP_DEFAULT) begin failures++; $display("[TB] FAIL b2b_drain got=%0b/%h exp=0/%h", ov1, od1, NOP_DEFAULT); end
    endtask

    task automatic test_skid_backpressure;
        logic [0:7]  vIv = 8'b1111_1100;
        logic [0:7]  vOr = 8'b1000_1111;
        logic [0:7]  eIr = 8'b1100_0111;
        logic [0:7]  eOv = 8'b0111_1110;
        logic [31:0] vId [8];
        logic [31:0] eOd [8];
        vId = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0003,
                32'hB000_0003, 32'hB000_0003, 32'h0, 32'h0};
        eOd = '{NOP_DEFAULT, 32'hB000_0001, 32'hB000_0001, 32'hB000_0001,
                32'hB000_0001, 32'hB000_0002, 32'hB000_0003, NOP_DEFAULT};
        for (int c = 0; c < 8; c++) begin
            iv1 = vIv[c];
            or1 = vOr[c];
            id1 = vId[c];
            #1;
            checks++; if (ir1 !== eIr[c]) begin failures++; $display("[TB] FAIL skid_ready c%0d got=%0b exp=%0b", c, ir1, eIr[c]); end
            checks++; if (ov1 !== eOv[c]) begin failures++; $display("[TB] FAIL skid_valid c%0d got=%0b exp=%0b", c, ov1, eOv[c]); end
            checks++; if (od1 !== eOd[c]) begin failures++; $display("[TB] FAIL skid_data c%0d got=%h exp=%h", c, od1, eOd[c]); end
            tick;
        end
    endtask

    task automatic test_bubble_flush;
        or1 = 1'b0; iv1 = 1'b1; id1 = 32'hC000_0001;
        tick;
        id1 = 32'hC000_0002;
        #1;
        checks++; if (ir1 !== 1'b1) begin failures++; $display("[TB] FAIL flush_fill_ready got=%0b exp=1", ir1); end
        tick;
        iv1 = 1'b0; bb1 = 1'b1;
        #1;
        checks++; if (ov1 !== 1'b0 || ir1 !== 1'b0) begin failures++; $display("[TB] FAIL flush_during got=%0b/%0b exp=0/0", ov1, ir1); end
        tick;
        bb1 = 1'b0;
        #1;
        checks++; if (ov1 !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%0b exp=0", ov1); end
        checks++; if (od1 !== NOP_DEFAULT) begin failures++; $display("[TB] FAIL flush_data got=%h exp=%h", od1, NOP_DEFAULT); end
        checks++; if (fc1 !== 16'd2) begin failures++; $display("[TB] FAIL flush_cnt got=%0d exp=2", fc1); end
        checks++; if (ir1 !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready got=%0b exp=1", ir1); end
    endtask

    task automatic test_stall;
        or1 = 1'b1; iv1 = 1'b1; id1 = 32'hD000_0005;
        tick;
        id1 = 32'hD000_0006; st1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (ov1 !== 1'b0 || ir1 !== 1'b0) begin failures++; $display("[TB] FAIL stall_hold%0d got=%0b/%0b exp=0/0", k, ov1, ir1); end
            tick;
        end
        st1 = 1'b0; iv1 = 1'b0;
        #1;
        checks++; if (sc1 !== 16'd5) begin failures++; $display("[TB] FAIL stall_cnt got=%0d exp=5", sc1); end
        checks++; if (ov1 !== 1'b1 || od1 !== 32'hD000_0005) begin failures++; $display("[TB] FAIL stall_release got=%0b/%h exp=1/d0000005", ov1, od1); end
        tick;
        checks++; if (ov1 !== 1'b0) begin failures++; $display("[TB] FAIL stall_once got=%0b exp=0", ov1); end
    endtask

    task automatic test_stall_bubble;
        or1 = 1'b0; iv1 = 1'b1; id1 = 32'hE000_0007;
        tick;
        iv1 = 1'b0; st1 = 1'b1; bb1 = 1'b1;
        #1;
        checks++; if (ov1 !== 1'b0 || ir1 !== 1'b0) begin failures++; $display("[TB] FAIL stbb_during got=%0b/%0b exp=0/0", ov1, ir1); end
        tick;
        st1 = 1'b0; bb1 = 1'b0; or1 = 1'b1;
        #1;
        checks++; if (ov1 !== 1'b0 || od1 !== NOP_DEFAULT) begin failures++; $display("[TB] FAIL stbb_empty got=%0b/%h exp=0/%h", ov1, od1, NOP_DEFAULT); end
        checks++; if (sc1 !== 16'd5) begin failures++; $display("[TB] FAIL stbb_stall_cnt got=%0d exp=5", sc1); end
        checks++; if (fc1 !== 16'd3) begin failures++; $display("[TB] FAIL stbb_flush_cnt got=%0d exp=3", fc1); end
    endtask

    task automatic test_noskid_handshake;
        logic [0:4]  vIv = 5'b11100;
        logic [0:4]  vOr = 5'b10111;
        logic [0:4]  eIr = 5'b10111;
        logic [0:4]  eOv = 5'b01110;
        logic [31:0] vId [5];
        logic [31:0] eOd [5];
        vId = '{32'hF000_0001, 32'hF000_0002, 32'hF000_0002, 32'h0, 32'h0};
        eOd = '{NOP_DEFAULT, 32'hF000_0001, 32'hF000_0001, 32'hF000_0002, NOP_DEFAULT};
        for (int c = 0; c < 5; c++) begin
            iv0 = vIv[c];
            or0 = vOr[c];
            id0 = vId[c];
            #1;
            checks++; if (ir0 !== eIr[c]) begin failures++; $display("[TB] FAIL noskid_ready c%0d got=%0b exp=%0b", c, ir0, eIr[c]); end
            checks++; if (ov0 !== eOv[c]) begin failures++; $display("[TB] FAIL noskid_valid c%0d got=%0b exp=%0b", c, ov0, eOv[c]); end
            checks++; if (od0 !== eOd[c]) begin failures++; $display("[TB] FAIL noskid_data c%0d got=%h exp=%h", c, od0, eOd[c]); end
            tick;
        end
    endtask

    task automatic test_saturation;
        st0 = 1'b1;
        for (int k = 0; k < 6; k++) tick;
        checks++; if (sc0 !== 2'd3) begin failures++; $display("[TB] FAIL sat_cnt got=%0d exp=3", sc0); end
        cc0 = 1'b1;
        tick;
        cc0 = 1'b0; st0 = 1'b0;
        #1;
        checks++; if (sc0 !== 2'd0) begin failures++; $display("[TB] FAIL sat_clr got=%0d exp=0", sc0); end
    endtask

    task automatic test_reset_mid;
        or0 = 1'b0; iv0 = 1'b1; id0 = 32'h9000_0008;
        tick;
        iv0 = 1'b0; st0 = 1'b1;
        tick;
        tick;
        st0 = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b1 || od0 !== 32'h9000_0008) begin failures++; $display("[TB] FAIL rstmid_pre got=%0b/%h exp=1/90000008", ov0, od0); end
        checks++; if (sc0 !== 2'd2) begin failures++; $display("[TB] FAIL rstmid_cnt_pre got=%0d exp=2", sc0); end
        r0 = 1'b1;
        #1;
        checks++; if (ov0 !== 1'b0 || od0 !== NOP_DEFAULT) begin failures++; $display("[TB] FAIL rstmid_out got=%0b/%h exp=0/%h", ov0, od0, NOP_DEFAULT); end
        checks++; if (sc0 !== 2'd0 || ir0 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_cnt_ready got=%0d/%0b exp=0/0", sc0, ir0); end
        tick;
        r0 = 1'b0; or0 = 1'b1;
        #1;
        checks++; if (ov0 !== 1'b0 || ir0 !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_after got=%0b/%0b exp=0/1", ov0, ir0); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_skid_backpressure;
        test_bubble_flush;
        test_stall;
        test_stall_bubble;
        test_noskid_handshake;
        test_saturation;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
